lot_gate_sequencer: RTL and testbench

- Upstream front end of the parking-lot tracker.
- Turns two raw photo-sensor levels into single-cycle car_in/car_out pulses, tracks lot occupancy with full/empty flags, and turns the hour push-button into hour/wr_en strobes.
- Issues one start pulse after the eighth hour so the downstream RAM tracker begins its read-back sweep.

---
 rtl/lot_gate_sequencer_if.sv | 42 ++++
 rtl/lot_gate_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_lot_gate_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lot_gate_sequencer_if.sv
// ---------------------------------------------------------------------------
// lot_gate_sequencer_if
// Groups the gate sequencer's sensor inputs and tracker-facing outputs.
//   master : drives the raw sensor/button levels and observes the outputs
//   slave  : the sequencer itself
// Signals:
//   sensor_a, sensor_b, hour_btn   raw asynchronous levels (1 = active)
//   car_in, car_out                one-cycle entry/exit pulses
//   occupancy, full, empty         lot occupancy and its flags
//   hour, wr_en                    one-cycle hour / RAM write strobes
//   hours_elapsed, day_done, start hour count, sticky day flag, sweep start
// ---------------------------------------------------------------------------
interface lot_gate_sequencer_if #(
  parameter int OCC_W = 4,
  parameter int HE_W  = 4
);
  logic             sensor_a;
  logic             sensor_b;
  logic             hour_btn;
  logic             car_in;
  logic             car_out;
  logic [OCC_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             hour;
  logic             wr_en;
  logic [HE_W-1:0]  hours_elapsed;
  logic             day_done;
  logic             start;

  modport master (
    output sensor_a, sensor_b, hour_btn,
    input  car_in, car_out, occupancy, full, empty,
    input  hour, wr_en, hours_elapsed, day_done, start
  );

  modport slave (
    input  sensor_a, sensor_b, hour_btn,
    output car_in, car_out, occupancy, full, empty,
    output hour, wr_en, hours_elapsed, day_done, start
  );
endinterface

// File: rtl/lot_gate_sequencer.sv
// ---------------------------------------------------------------------------
// lot_gate_sequencer
// Front end of the parking-lot tracker. Synchronizes two photo-sensor beams
// and the hour button, decodes beam order into car_in/car_out pulses, keeps a
// saturating occupancy count, and issues hour/wr_en strobes plus a single
// start pulse once the day's last hour has been logged.
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous active-high reset
//   bus    lot_gate_sequencer_if.slave (sensor inputs, all status outputs)
// ---------------------------------------------------------------------------
module lot_gate_sequencer #(
  parameter int CAPACITY = 3,
  parameter int OCC_W    = 4,
  parameter int HOURS    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  lot_gate_sequencer_if.slave  bus
);

  localparam int HE_W = $clog2(HOURS) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN_A  = 3'd1,
    EN_AB = 3'd2,
    EN_B  = 3'd3,
    EX_B  = 3'd4,
    EX_BA = 3'd5,
    EX_A  = 3'd6,
    ABORT = 3'd7
  } gate_state_t;

  logic        sa_meta_r, sa_sync_r;
  logic        sb_meta_r, sb_sync_r;
  logic        hb_meta_r, hb_sync_r;
  logic        hb_prev_r;
  logic [1:0]  ab_s;

  gate_state_t state_r, state_next_s;
  logic        car_in_s, car_out_s;
  logic        car_in_r, car_out_r;
  logic [OCC_W-1:0] occupancy_r;

  logic        hour_strobe_s;
  logic        hour_r;
  logic [HE_W-1:0] hours_r;
  logic        day_done_r, day_done_d_r;
  logic        start_r;

  // Two-flop synchronizers for the three raw asynchronous inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sa_meta_r <= 1'b0;
      sa_sync_r <= 1'b0;
      sb_meta_r <= 1'b0;
      sb_sync_r <= 1'b0;
      hb_meta_r <= 1'b0;
      hb_sync_r <= 1'b0;
    end else begin
      sa_meta_r <= bus.sensor_a;
      sa_sync_r <= sa_meta_r;
      sb_meta_r <= bus.sensor_b;
      sb_sync_r <= sb_meta_r;
      hb_meta_r <= bus.hour_btn;
      hb_sync_r <= hb_meta_r;
    end
  end

  assign ab_s = {sa_sync_r, sb_sync_r};

  // Direction FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Direction FSM next state; entry walks a -> ab -> b -> clear, exit mirrors.
  always_comb begin
    state_next_s = state_r;
    car_in_s     = 1'b0;
    car_out_s    = 1'b0;
    case (state_r)
      IDLE: begin
        case (ab_s)
          2'b10:   state_next_s = EN_A;
          2'b01:   state_next_s = EX_B;
          2'b11:   state_next_s = ABORT;
          default: state_next_s = IDLE;
        endcase
      end
      EN_A: begin
        case (ab_s)
          2'b11:   state_next_s = EN_AB;
          2'b00:   state_next_s = IDLE;   // backed out, not counted
          2'b01:   state_next_s = ABORT;
          default: state_next_s = EN_A;
        endcase
      end
      EN_AB: begin
        case (ab_s)
          2'b01:   state_next_s = EN_B;
          2'b10:   state_next_s = EN_A;
          2'b00:   state_next_s = ABORT;
          default: state_next_s = EN_AB;
        endcase
      end
      EN_B: begin
        case (ab_s)
          2'b00: begin
            state_next_s = IDLE;
            car_in_s     = 1'b1;
          end
          2'b11:   state_next_s = EN_AB;
          2'b10:   state_next_s = ABORT;
          default: state_next_s = EN_B;
        endcase
      end
      EX_B: begin
        case (ab_s)
          2'b11:   state_next_s = EX_BA;
          2'b00:   state_next_s = IDLE;
          2'b10:   state_next_s = ABORT;
          default: state_next_s = EX_B;
        endcase
      end
      EX_BA: begin
        case (ab_s)
          2'b10:   state_next_s = EX_A;
          2'b01:   state_next_s = EX_B;
          2'b00:   state_next_s = ABORT;
          default: state_next_s = EX_BA;
        endcase
      end
      EX_A: begin
        case (ab_s)
          2'b00: begin
            state_next_s = IDLE;
            car_out_s    = 1'b1;
          end
          2'b11:   state_next_s = EX_BA;
          2'b01:   state_next_s = ABORT;
          default: state_next_s = EX_A;
        endcase
      end
      ABORT: begin
        if (ab_s == 2'b00) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ABORT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Registered car pulses and saturating occupancy, updated on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      car_in_r    <= 1'b0;
      car_out_r   <= 1'b0;
      occupancy_r <= '0;
    end else begin
      car_in_r  <= car_in_s;
      car_out_r <= car_out_s;
      // Pulses still fire at the limits; only the count saturates.
      if (car_in_s) begin
        if (occupancy_r != OCC_W'(CAPACITY)) begin
          occupancy_r <= occupancy_r + {{(OCC_W-1){1'b0}}, 1'b1};
        end else begin
          occupancy_r <= occupancy_r;
        end
      end else if (car_out_s) begin
        if (occupancy_r != {OCC_W{1'b0}}) begin
          occupancy_r <= occupancy_r - {{(OCC_W-1){1'b0}}, 1'b1};
        end else begin
          occupancy_r <= occupancy_r;
        end
      end else begin
        occupancy_r <= occupancy_r;
      end
    end
  end

  // A held button yields one strobe; strobes stop once the day is complete.
  assign hour_strobe_s = hb_sync_r & ~hb_prev_r & ~day_done_r;

  // Hour strobe, hour counter, sticky day_done and the delayed start pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hb_prev_r    <= 1'b0;
      hour_r       <= 1'b0;
      hours_r      <= '0;
      day_done_r   <= 1'b0;
      day_done_d_r <= 1'b0;
      start_r      <= 1'b0;
    end else begin
      hb_prev_r    <= hb_sync_r;
      hour_r       <= hour_strobe_s;
      day_done_d_r <= day_done_r;
      start_r      <= day_done_r & ~day_done_d_r;
      if (hour_strobe_s) begin
        hours_r <= hours_r + {{(HE_W-1){1'b0}}, 1'b1};
        if (hours_r == HE_W'(HOURS - 1)) begin
          day_done_r <= 1'b1;
        end else begin
          day_done_r <= day_done_r;
        end
      end else begin
        hours_r    <= hours_r;
        day_done_r <= day_done_r;
      end
    end
  end

  assign bus.car_in        = car_in_r;
  assign bus.car_out       = car_out_r;
  assign bus.occupancy     = occupancy_r;
  assign bus.full          = (occupancy_r == OCC_W'(CAPACITY));
  assign bus.empty         = (occupancy_r == {OCC_W{1'b0}});
  assign bus.hour          = hour_r;
  assign bus.wr_en         = hour_r;
  assign bus.hours_elapsed = hours_r;
  assign bus.day_done      = day_done_r;
  assign bus.start         = start_r;

endmodule

// File: tb/tb_lot_gate_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lot_gate_sequencer
// Drives raw sensor/button levels at falling edges and samples outputs at
// falling edges. Expected car pulses come from a position-along-the-gate
// model: a car walks positions 1,2,3 in one direction, every beam change must
// move it by exactly one position, and clearing from position 3 counts it.
// ---------------------------------------------------------------------------
module tb_lot_gate_sequencer;

  localparam int CAP   = 3;
  localparam int OCC_W = 4;
  localparam int HOURS = 8;
  localparam int HE_W  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  lot_gate_sequencer_if #(.OCC_W(OCC_W), .HE_W(HE_W)) bus ();

  lot_gate_sequencer #(.CAPACITY(CAP), .OCC_W(OCC_W), .HOURS(HOURS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state: direction 0 idle, 1 entering, 2 exiting, 3 aborted.
  int         m_dir;
  int         m_pos;
  logic [1:0] m_prev;
  int         m_occ;
  int         m_hours;

  function automatic int pos_of(input int dir, input logic [1:0] v);
    if (v == 2'b11) return 2;
    if (v == 2'b00) return 0;
    if (dir == 1) return (v == 2'b10) ? 1 : 3;
    return (v == 2'b01) ? 1 : 3;
  endfunction

  function automatic void model_reset();
    m_dir = 0; m_pos = 0; m_prev = 2'b00; m_occ = 0; m_hours = 0;
  endfunction

  function automatic void model_step(input logic [1:0] v, output int pin, output int pout);
    int p;
    pin = 0; pout = 0;
    if (v != m_prev) begin
      if (m_dir == 0) begin
        if (v == 2'b10) begin m_dir = 1; m_pos = 1; end
        else if (v == 2'b01) begin m_dir = 2; m_pos = 1; end
        else if (v == 2'b11) m_dir = 3;
      end else if (m_dir == 3) begin
        if (v == 2'b00) m_dir = 0;
      end else begin
        p = pos_of(m_dir, v);
        if (v == 2'b00) begin
          if (m_pos == 3) begin
            if (m_dir == 1) pin = 1; else pout = 1;
          end
          m_dir = 0;
        end else if (p - m_pos == 1 || m_pos - p == 1) begin
          m_pos = p;
        end else begin
          m_dir = 3;
        end
      end
    end
    m_prev = v;
    if (pin == 1 && m_occ < CAP) m_occ++;
    if (pout == 1 && m_occ > 0) m_occ--;
  endfunction

  // Observation record of one held input value.
  int ob_in_cnt, ob_in_idx, ob_out_cnt, ob_out_idx, ob_hour_cnt, ob_hour_idx;
  int ob_wr_diff, ob_start_cnt, ob_start_idx;

  task automatic observe(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (bus.car_in === 1'b1) begin ob_in_cnt++; if (ob_in_idx < 0) ob_in_idx = i; end
      if (bus.car_out === 1'b1) begin ob_out_cnt++; if (ob_out_idx < 0) ob_out_idx = i; end
      if (bus.hour === 1'b1) begin ob_hour_cnt++; if (ob_hour_idx < 0) ob_hour_idx = i; end
      if (bus.start === 1'b1) begin ob_start_cnt++; if (ob_start_idx < 0) ob_start_idx = i; end
      if (bus.wr_en !== bus.hour) ob_wr_diff++;
    end
  endtask

  task automatic clear_obs();
    ob_in_cnt = 0; ob_in_idx = -1; ob_out_cnt = 0; ob_out_idx = -1;
    ob_hour_cnt = 0; ob_hour_idx = -1; ob_wr_diff = 0;
    ob_start_cnt = 0; ob_start_idx = -1;
  endtask

  // Applies one raw sensor value for 'hold' cycles and checks it against the model.
  task automatic sensor_step(input logic [1:0] v, input int hold, input string tag);
    int pin, pout;
    model_step(v, pin, pout);
    clear_obs();
    bus.sensor_a = v[1];
    bus.sensor_b = v[0];
    observe(hold);
    checks++;
    if (ob_in_cnt != pin || (pin == 1 && ob_in_idx != 2)) begin
      errors++;
      $display("FAIL %s car_in: got %0d pulses at idx %0d, want %0d at idx 2", tag, ob_in_cnt, ob_in_idx, pin);
    end
    checks++;
    if (ob_out_cnt != pout || (pout == 1 && ob_out_idx != 2)) begin
      errors++;
      $display("FAIL %s car_out: got %0d pulses at idx %0d, want %0d at idx 2", tag, ob_out_cnt, ob_out_idx, pout);
    end
    checks++;
    if (bus.occupancy !== OCC_W'(m_occ) || bus.empty !== (m_occ == 0) || bus.full !== (m_occ == CAP)) begin
      errors++;
      $display("FAIL %s occupancy: got %0d full %b empty %b, want %0d", tag, bus.occupancy, bus.full, bus.empty, m_occ);
    end
    checks++;
    if (ob_hour_cnt != 0) begin
      errors++;
      $display("FAIL %s stray hour: got %0d strobes, want 0", tag, ob_hour_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.sensor_a = 1'b0; bus.sensor_b = 1'b0; bus.hour_btn = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    checks++;
    if (bus.car_in !== 1'b0 || bus.car_out !== 1'b0 || bus.occupancy !== 4'd0 || bus.full !== 1'b0 ||
        bus.empty !== 1'b1 || bus.hour !== 1'b0 || bus.wr_en !== 1'b0 || bus.hours_elapsed !== 4'd0 ||
        bus.day_done !== 1'b0 || bus.start !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got occ %0d empty %b hours %0d day_done %b, want 0/1/0/0",
               bus.occupancy, bus.empty, bus.hours_elapsed, bus.day_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_entry();
    sensor_step(2'b00, 4, "entry00");
    sensor_step(2'b10, 4, "entry10");
    sensor_step(2'b11, 4, "entry11");
    sensor_step(2'b01, 4, "entry01");
    sensor_step(2'b00, 4, "entry_done");
    checks++;
    if (bus.occupancy !== 4'd1 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL entry_occ: got %0d empty %b, want 1 empty 0", bus.occupancy, bus.empty);
    end
  endtask

  task automatic test_exit();
    sensor_step(2'b01, 4, "exit01");
    sensor_step(2'b11, 4, "exit11");
    sensor_step(2'b10, 4, "exit10");
    sensor_step(2'b00, 4, "exit_done");
    checks++;
    if (bus.occupancy !== 4'd0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL exit_occ: got %0d empty %b, want 0 empty 1", bus.occupancy, bus.empty);
    end
  endtask

  task automatic test_partial_abort();
    sensor_step(2'b10, 4, "partial10");
    sensor_step(2'b11, 5, "partial11");
    sensor_step(2'b10, 4, "partial10b");
    sensor_step(2'b00, 4, "partial00");
    sensor_step(2'b11, 5, "glitch11");
    sensor_step(2'b01, 4, "abort01");
    sensor_step(2'b00, 4, "abort00");
  endtask

  task automatic test_capacity();
    for (int k = 0; k < 4; k++) begin
      sensor_step(2'b10, 4, "cap10");
      sensor_step(2'b11, 4, "cap11");
      sensor_step(2'b01, 4, "cap01");
      sensor_step(2'b00, 4, "cap00");
    end
    checks++;
    if (bus.occupancy !== 4'd3 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL capacity: got occ %0d full %b, want 3 full 1", bus.occupancy, bus.full);
    end
    for (int k = 0; k < 4; k++) begin
      sensor_step(2'b01, 4, "drain01");
      sensor_step(2'b11, 4, "drain11");
      sensor_step(2'b10, 4, "drain10");
      sensor_step(2'b00, 4, "drain00");
    end
  endtask

  task automatic test_random_traffic();
    logic [1:0] v;
    for (int k = 0; k < 80; k++) begin
      // Bias toward neighbouring patterns so full passages actually occur.
      if ($urandom_range(0, 3) == 0) v = 2'($urandom_range(0, 3));
      else v = m_prev ^ (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
      sensor_step(v, int'($urandom_range(4, 7)), "random");
    end
    sensor_step(2'b00, 4, "random_end");
  endtask

  task automatic test_back_to_back();
    int pin, pout;
    sensor_step(2'b10, 4, "b2b10");
    sensor_step(2'b11, 4, "b2b11");
    sensor_step(2'b01, 4, "b2b01");
    model_step(2'b00, pin, pout);
    clear_obs();
    bus.sensor_a = 1'b0; bus.sensor_b = 1'b0; bus.hour_btn = 1'b1;
    observe(6);
    if (m_hours < HOURS) m_hours++;
    checks++;
    if (ob_in_cnt != 1 || ob_in_idx != 2 || ob_hour_cnt != 1 || ob_hour_idx != 2 || ob_wr_diff != 0) begin
      errors++;
      $display("FAIL b2b: car_in %0d@%0d hour %0d@%0d wr_diff %0d, want 1@2 1@2 0",
               ob_in_cnt, ob_in_idx, ob_hour_cnt, ob_hour_idx, ob_wr_diff);
    end
    checks++;
    if (bus.occupancy !== OCC_W'(m_occ) || bus.hours_elapsed !== HE_W'(m_hours)) begin
      errors++;
      $display("FAIL b2b_counts: got occ %0d hours %0d, want %0d %0d",
               bus.occupancy, bus.hours_elapsed, m_occ, m_hours);
    end
    bus.hour_btn = 1'b0;
    observe(6);
  endtask

  task automatic test_hours();
    int presses;
    int want_hour, want_start;
    presses = HOURS - m_hours + 1;
    for (int k = 0; k < presses; k++) begin
      want_hour  = (m_hours < HOURS) ? 1 : 0;
      if (want_hour == 1) m_hours++;
      want_start = (want_hour == 1 && m_hours == HOURS) ? 1 : 0;
      clear_obs();
      bus.hour_btn = 1'b1;
      observe(6);
      bus.hour_btn = 1'b0;
      observe(6);
      checks++;
      if (ob_hour_cnt != want_hour || (want_hour == 1 && ob_hour_idx != 2) || ob_wr_diff != 0) begin
        errors++;
        $display("FAIL hour_strobe press %0d: got %0d@%0d wr_diff %0d, want %0d@2",
                 k, ob_hour_cnt, ob_hour_idx, ob_wr_diff, want_hour);
      end
      checks++;
      if (bus.hours_elapsed !== HE_W'(m_hours) || bus.day_done !== (m_hours == HOURS)) begin
        errors++;
        $display("FAIL hour_count press %0d: got %0d day_done %b, want %0d", k, bus.hours_elapsed, bus.day_done, m_hours);
      end
      checks++;
      if (ob_start_cnt != want_start || (want_start == 1 && ob_start_idx != 3)) begin
        errors++;
        $display("FAIL start press %0d: got %0d@%0d, want %0d@3", k, ob_start_cnt, ob_start_idx, want_start);
      end
    end
  endtask

  task automatic test_reset_mid();
    sensor_step(2'b10, 4, "mid_entry");
    sensor_step(2'b11, 4, "mid_11");
    sensor_step(2'b01, 4, "mid_01");
    sensor_step(2'b00, 4, "mid_done");
    sensor_step(2'b10, 4, "mid10");
    sensor_step(2'b11, 4, "mid11");
    // Assert reset between clock edges; outputs must clear without an edge.
    #2;
    reset = 1'b1;
    bus.sensor_a = 1'b0; bus.sensor_b = 1'b0;
    #1;
    checks++;
    if (bus.occupancy !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.day_done !== 1'b0 ||
        bus.hours_elapsed !== 4'd0 || bus.start !== 1'b0 || bus.car_in !== 1'b0 || bus.hour !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got occ %0d empty %b day_done %b hours %0d, want 0 1 0 0",
               bus.occupancy, bus.empty, bus.day_done, bus.hours_elapsed);
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    sensor_step(2'b00, 4, "post00");
    sensor_step(2'b10, 4, "post10");
    sensor_step(2'b11, 4, "post11");
    sensor_step(2'b01, 4, "post01");
    sensor_step(2'b00, 4, "post_done");
    checks++;
    if (bus.occupancy !== 4'd1) begin
      errors++;
      $display("FAIL post_reset_entry: got occ %0d, want 1", bus.occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_partial_abort();
    test_capacity();
    test_random_traffic();
    test_back_to_back();
    test_hours();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
